// File: rtl/pu_read_stream_model_pkg.sv
// Shared types and constants for the PU buffer read stream model.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package pu_read_stream_model_pkg;

    // Stream controller states (2-bit encoding)
    typedef enum logic [1:0] {
        PU_RSM_IDLE   = 2'd0,
        PU_RSM_STREAM = 2'd1,
        PU_RSM_DRAIN  = 2'd2,
        PU_RSM_DONE   = 2'd3
    } rsm_state_e;

    // Fibonacci LFSR taps 8,6,5,4 expressed as bit mask over lfsr[7:0]
    localparam logic [7:0] PU_RSM_LFSR_TAPS = 8'hB8;
    // A zero seed would lock the LFSR, so it is replaced by this value
    localparam logic [7:0] PU_RSM_SEED_DEFAULT = 8'h01;

    // Index width helper: never narrower than one bit
    function automatic int c_log_2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One LFSR step: shift left, feedback is XOR of the tapped bits
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & PU_RSM_LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/pu_read_stream_model_delay_line.sv
// Fixed-depth shift register carrying {valid,last,data} from read issue to read return.
// Latency: exactly LATENCY cycles from in_* to out_*.
// Backpressure: none; every cycle shifts, data stages only load on valid so the output holds.
module pu_rsm_delay_line #(
    parameter int DATA_WIDTH = 64,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  pending
);

    logic [LATENCY-1:0]    vld_q;
    logic [LATENCY-1:0]    last_q;
    logic [DATA_WIDTH-1:0] dat_q  [LATENCY];
    logic [LATENCY-1:0]    vld_in;
    logic [LATENCY-1:0]    last_in;
    logic [DATA_WIDTH-1:0] dat_in [LATENCY];

    // Stage inputs: stage 0 takes the new issue, later stages take their predecessor
    always_comb begin
        vld_in     = '0;
        last_in    = '0;
        vld_in[0]  = in_valid;
        last_in[0] = in_last;
        dat_in[0]  = in_data;
        for (int i = 1; i < LATENCY; i++) begin
            vld_in[i]  = vld_q[i-1];
            last_in[i] = last_q[i-1];
            dat_in[i]  = dat_q[i-1];
        end
    end

    // Shift every cycle; reset flushes everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            last_q <= '0;
            for (int i = 0; i < LATENCY; i++) dat_q[i] <= '0;
        end else begin
            vld_q  <= vld_in;
            last_q <= last_in;
            for (int i = 0; i < LATENCY; i++) begin
                if (vld_in[i]) dat_q[i] <= dat_in[i];
            end
        end
    end

    // Words still in flight ahead of the output stage
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < LATENCY - 1; i++) pending = pending | vld_q[i];
    end

    assign out_valid = vld_q[LATENCY-1];
    assign out_last  = last_q[LATENCY-1];
    assign out_data  = dat_q[LATENCY-1];

endmodule

// File: rtl/pu_read_stream_model.sv
// Streams preloaded per-channel memories over the PU buffer read handshake (single or round-robin).
// Latency: LATENCY cycles from an accepted buffer_read_req to buffer_read_data_valid.
// Backpressure: consumer-paced via read_req; buffer_read_empty (incl. LFSR stalls) blocks issue.
module pu_read_stream_model
    import pu_read_stream_model_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_CH     = 4,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 2,
    parameter int CNT_W      = 16,
    parameter int CH_W       = c_log_2(NUM_CH),
    parameter int ADDR_W     = c_log_2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    input  logic [CH_W-1:0]       load_ch,
    input  logic [ADDR_W-1:0]     load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [ADDR_W:0]       cfg_len,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic                  cfg_mode,
    input  logic                  cfg_stall_en,
    input  logic [7:0]            cfg_stall_seed,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic                  buffer_read_req,
    output logic                  buffer_read_empty,
    output logic                  buffer_read_data_valid,
    output logic [DATA_WIDTH-1:0] buffer_read_data_out,
    output logic                  buffer_read_last,
    input  logic                  wr_req,
    output logic [CNT_W-1:0]      wr_count,
    output logic                  error
);

    localparam int TOT_W    = ADDR_W + 1 + CH_W;
    localparam int CH_SHIFT = $clog2(NUM_CH);

    rsm_state_e            state, state_nxt;
    logic [ADDR_W:0]       len_q;
    logic                  mode_q;
    logic                  stall_en_q;
    logic [7:0]            lfsr;
    logic [CH_W-1:0]       cur_ch;
    logic [ADDR_W-1:0]     cur_addr;
    logic [TOT_W-1:0]      issued;
    logic [TOT_W-1:0]      total;
    logic                  all_issued;
    logic                  last_issue;
    logic                  stall;
    logic                  accept;
    logic                  start_ok;
    logic                  pipe_pending;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] mem [NUM_CH*DEPTH];

    assign start_ok   = start && (state == PU_RSM_IDLE);
    assign total      = mode_q ? (TOT_W'(len_q) << CH_SHIFT) : TOT_W'(len_q);
    assign all_issued = (issued == total);
    assign last_issue = (issued == total - TOT_W'(1));
    assign stall      = stall_en_q & lfsr[0] & lfsr[1];

    assign buffer_read_empty = (state != PU_RSM_STREAM) | all_issued | stall;
    assign accept            = buffer_read_req & ~buffer_read_empty;
    assign busy              = (state != PU_RSM_IDLE);
    assign done              = (state == PU_RSM_DONE);
    assign rd_data           = mem[{cur_ch, cur_addr}];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= PU_RSM_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: zero-length streams skip DRAIN since nothing is in flight
    always_comb begin
        state_nxt = state;
        case (state)
            PU_RSM_IDLE:   if (start) state_nxt = PU_RSM_STREAM;
            PU_RSM_STREAM: begin
                if (all_issued)                state_nxt = PU_RSM_DONE;
                else if (accept && last_issue) state_nxt = PU_RSM_DRAIN;
            end
            PU_RSM_DRAIN:  if (!pipe_pending) state_nxt = PU_RSM_DONE;
            PU_RSM_DONE:   state_nxt = PU_RSM_IDLE;
            default:       state_nxt = PU_RSM_IDLE;
        endcase
    end

    // Stream config latch, issue address walk and stall LFSR
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q      <= '0;
            mode_q     <= 1'b0;
            stall_en_q <= 1'b0;
            lfsr       <= PU_RSM_SEED_DEFAULT;
            cur_ch     <= '0;
            cur_addr   <= '0;
            issued     <= '0;
        end else if (start_ok) begin
            len_q      <= cfg_len;
            mode_q     <= cfg_mode;
            stall_en_q <= cfg_stall_en;
            lfsr       <= (cfg_stall_seed == 8'h00) ? PU_RSM_SEED_DEFAULT : cfg_stall_seed;
            cur_ch     <= cfg_mode ? '0 : cfg_ch;
            cur_addr   <= '0;
            issued     <= '0;
        end else if (state == PU_RSM_STREAM) begin
            lfsr <= lfsr_next(lfsr);
            if (accept) begin
                issued <= issued + TOT_W'(1);
                if (!mode_q) begin
                    cur_addr <= cur_addr + ADDR_W'(1);
                end else if (cur_ch == CH_W'(NUM_CH - 1)) begin
                    cur_ch   <= '0;
                    cur_addr <= cur_addr + ADDR_W'(1);
                end else begin
                    cur_ch <= cur_ch + CH_W'(1);
                end
            end
        end
    end

    // Channel memories; loads only land while idle so they never race a read
    always_ff @(posedge clk) begin
        if (load_valid && (state == PU_RSM_IDLE)) mem[{load_ch, load_addr}] <= load_data;
    end

    // Sticky protocol error: request while empty, or load while busy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                                     error <= 1'b0;
        else if ((buffer_read_req && buffer_read_empty) || (load_valid && busy)) error <= 1'b1;
    end

    // Saturating PU write-beat counter, cleared by an accepted start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                      wr_count <= '0;
        else if (start_ok)               wr_count <= '0;
        else if (wr_req && !(&wr_count)) wr_count <= wr_count + CNT_W'(1);
    end

    pu_rsm_delay_line #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (LATENCY)
    ) u_delay (
        .clk       (clk),
        .rst_n     (reset),
        .in_valid  (accept),
        .in_last   (last_issue),
        .in_data   (rd_data),
        .out_valid (buffer_read_data_valid),
        .out_last  (buffer_read_last),
        .out_data  (buffer_read_data_out),
        .pending   (pipe_pending)
    );

endmodule

// File: tb/tb_pu_read_stream_model.sv
// Directed + randomized bench for pu_read_stream_model with a queue-based reference model.
// Latency: checks data arrives exactly LATENCY cycles after each accepted request.
// Backpressure: requests are gated by the model's own view of empty/stall.
module tb_pu_read_stream_model;

    localparam int DW  = 64;
    localparam int NC  = 4;
    localparam int DP  = 16;
    localparam int LAT = 2;
    localparam int CW  = 4;
    localparam int CHW = 2;
    localparam int AW  = 4;
    localparam int LW  = AW + 1;

    logic           clk = 1'b0;
    logic           reset;
    logic           load_valid;
    logic [CHW-1:0] load_ch;
    logic [AW-1:0]  load_addr;
    logic [DW-1:0]  load_data;
    logic [AW:0]    cfg_len;
    logic [CHW-1:0] cfg_ch;
    logic           cfg_mode;
    logic           cfg_stall_en;
    logic [7:0]     cfg_stall_seed;
    logic           start;
    logic           busy;
    logic           done;
    logic           buffer_read_req;
    logic           buffer_read_empty;
    logic           buffer_read_data_valid;
    logic [DW-1:0]  buffer_read_data_out;
    logic           buffer_read_last;
    logic           wr_req;
    logic [CW-1:0]  wr_count;
    logic           error;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] ref_mem [NC][DP];
    bit            model_err = 0;

    pu_read_stream_model #(
        .DATA_WIDTH (DW),
        .NUM_CH     (NC),
        .DEPTH      (DP),
        .LATENCY    (LAT),
        .CNT_W      (CW)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .load_valid             (load_valid),
        .load_ch                (load_ch),
        .load_addr              (load_addr),
        .load_data              (load_data),
        .cfg_len                (cfg_len),
        .cfg_ch                 (cfg_ch),
        .cfg_mode               (cfg_mode),
        .cfg_stall_en           (cfg_stall_en),
        .cfg_stall_seed         (cfg_stall_seed),
        .start                  (start),
        .busy                   (busy),
        .done                   (done),
        .buffer_read_req        (buffer_read_req),
        .buffer_read_empty      (buffer_read_empty),
        .buffer_read_data_valid (buffer_read_data_valid),
        .buffer_read_data_out   (buffer_read_data_out),
        .buffer_read_last       (buffer_read_last),
        .wr_req                 (wr_req),
        .wr_count               (wr_count),
        .error                  (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input int c, input int a, input logic [DW-1:0] d);
        @(negedge clk);
        load_valid = 1'b1;
        load_ch    = CHW'(c);
        load_addr  = AW'(a);
        load_data  = d;
        ref_mem[c][a] = d;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    // Runs one stream against the reference model. abort_after>=0 returns as soon
    // as that many words have been delivered (used for the mid-stream reset).
    task automatic run_stream(input bit mode, input int len, input int ch, input bit sen,
                              input logic [7:0] seed, input bit rnd_req, input bit inj_start,
                              input bit inj_load, input int abort_after);
        int total, iss, nval, ndone, done_cyc, idx, ec, ea;
        logic [7:0] l;
        bit strm, exp_empty, exp_vld, want;
        int due_q[$];
        int idx_q[$];
        total = mode ? len * NC : len;
        @(negedge clk);
        cfg_len = LW'(len); cfg_ch = CHW'(ch); cfg_mode = mode;
        cfg_stall_en = sen; cfg_stall_seed = seed; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        l = (seed == 8'h00) ? 8'h01 : seed;
        strm = 1; iss = 0; nval = 0; ndone = 0; done_cyc = -1;
        for (int cyc = 1; cyc < 800; cyc++) begin
            if (cyc > 1) @(negedge clk);
            exp_empty = !strm || (iss == total) || (sen && l[0] && l[1]);
            chk("empty", buffer_read_empty, exp_empty);
            exp_vld = (due_q.size() > 0) && (due_q[0] == cyc);
            chk("valid", buffer_read_data_valid, exp_vld);
            if (exp_vld && buffer_read_data_valid) begin
                void'(due_q.pop_front());
                idx = idx_q.pop_front();
                ec = mode ? idx % NC : ch;
                ea = mode ? idx / NC : idx;
                chk("data", buffer_read_data_out, ref_mem[ec][ea]);
                chk("last", buffer_read_last, idx == total - 1);
                nval++;
            end
            if (done) begin ndone++; done_cyc = cyc; end
            chk("busy", busy, (done_cyc < 0) || (cyc == done_cyc));
            if (abort_after >= 0 && nval >= abort_after) begin
                buffer_read_req = 1'b0;
                return;
            end
            want = rnd_req ? ($urandom_range(0, 1) == 1) : 1'b1;
            buffer_read_req = want && !exp_empty;
            if (strm) begin
                if (buffer_read_req) begin
                    due_q.push_back(cyc + LAT);
                    idx_q.push_back(iss);
                    iss++;
                end
                l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
                if (iss == total) strm = 0;
            end
            if (inj_start && cyc == 2) begin
                start = 1'b1; cfg_len = LW'(1); cfg_mode = !mode; cfg_ch = CHW'(ch + 1);
            end
            if (inj_load && cyc == 2) begin
                load_valid = 1'b1; load_ch = CHW'(ch); load_addr = '0;
                load_data = ~ref_mem[ch][0];
                model_err = 1;
            end
            if (cyc == 3) begin start = 1'b0; load_valid = 1'b0; end
            if (done_cyc > 0 && cyc >= done_cyc + 2) break;
        end
        buffer_read_req = 1'b0;
        chk("words_delivered", nval, total);
        chk("done_pulses", ndone, 1);
        if (len == 0) chk("done_cycle_len0", done_cyc, 2);
        chk("error", error, model_err);
    endtask

    initial begin
        reset = 1'b0; load_valid = 0; load_ch = '0; load_addr = '0; load_data = '0;
        cfg_len = '0; cfg_ch = '0; cfg_mode = 0; cfg_stall_en = 0; cfg_stall_seed = '0;
        start = 0; buffer_read_req = 0; wr_req = 0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_empty", buffer_read_empty, 1);
        chk("rst_valid", buffer_read_data_valid, 0);
        chk("rst_last", buffer_read_last, 0);
        chk("rst_data", buffer_read_data_out, 0);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_error", error, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;

        // Fill every word with random data, then the directed single-mode pattern
        for (int c = 0; c < NC; c++)
            for (int a = 0; a < DP; a++)
                load_word(c, a, {$urandom, $urandom});
        for (int a = 0; a < 4; a++) load_word(2, a, 64'hA0 + 64'(a));
        run_stream(0, 4, 2, 0, 8'h00, 0, 0, 0, -1);

        // Interleave with word {c,a}
        for (int c = 0; c < NC; c++)
            for (int a = 0; a < 2; a++)
                load_word(c, a, (64'(c) << 32) | 64'(a));
        run_stream(1, 2, 0, 0, 8'h00, 0, 0, 0, -1);

        // Stall injection, fixed and random seeds, plus the zero-seed substitution
        run_stream(0, 16, 1, 1, 8'h5A, 0, 0, 0, -1);
        run_stream(1, DP, 0, 1, 8'($urandom_range(1, 255)), 1, 0, 0, -1);
        run_stream(0, 9, 3, 1, 8'h00, 1, 0, 0, -1);

        // Edge cases: empty stream, start ignored while busy, full-depth stream
        run_stream(0, 0, 1, 0, 8'h00, 0, 0, 0, -1);
        run_stream(0, 6, 0, 0, 8'h00, 0, 1, 0, -1);
        run_stream(0, DP, 3, 0, 8'h00, 1, 0, 0, -1);

        // Write-beat counter: partial count, saturation, start beats a wr_req
        for (int i = 0; i < 7; i++) begin @(negedge clk); wr_req = 1'b1; end
        @(negedge clk); wr_req = 1'b0;
        chk("wr_count_7", wr_count, 7);
        for (int i = 0; i < 13; i++) begin @(negedge clk); wr_req = 1'b1; end
        @(negedge clk); wr_req = 1'b0;
        chk("wr_count_sat", wr_count, 15);
        @(negedge clk);
        cfg_len = '0; cfg_mode = 0; cfg_stall_en = 0; start = 1'b1; wr_req = 1'b1;
        @(negedge clk);
        start = 1'b0; wr_req = 1'b0;
        chk("wr_count_start_clr", wr_count, 0);
        chk("busy_after_start", busy, 1);
        repeat (4) @(negedge clk);
        chk("idle_after_len0", busy, 0);

        // Protocol: read_req in IDLE, then a load during STREAM, then memory unchanged
        chk("error_before", error, 0);
        @(negedge clk); buffer_read_req = 1'b1;
        @(negedge clk); buffer_read_req = 1'b0;
        model_err = 1;
        chk("error_req_idle", error, 1);
        run_stream(0, 4, 1, 0, 8'h00, 0, 0, 1, -1);
        run_stream(0, 1, 1, 0, 8'h00, 0, 0, 0, -1);

        // Reset mid-stream after 3 of 8 words, then a clean restart from addr 0
        run_stream(0, 8, 2, 0, 8'h00, 0, 0, 0, 3);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", buffer_read_data_valid, 0);
        chk("mid_rst_last", buffer_read_last, 0);
        chk("mid_rst_data", buffer_read_data_out, 0);
        chk("mid_rst_empty", buffer_read_empty, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_error", error, 0);
        model_err = 0;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_quiet", {buffer_read_data_valid, done, busy}, 3'b000);
        end
        run_stream(0, 8, 2, 0, 8'h00, 0, 0, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
